// File: rtl/bram_lane_clr_pkg.sv
// Shared definitions for the byte-lane block RAM: lane width, clear FSM states
// and a helper that extracts one byte lane from a bus word.
package bram_pkg;

  localparam int LANE_W = 8;
  // Widest bus the slicing helper accepts (64 lanes).
  localparam int MAX_W  = 512;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_t;

  function automatic logic [LANE_W-1:0] lane_slice(input logic [MAX_W-1:0] word,
                                                   input int lane);
    return word[lane*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/bram_lane_clr_lane.sv
// One 8-bit true-dual-port read-first RAM lane. Each port has its own read and
// write address so a clear write can share a port with an unrelated read.
module bram_lane
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  re_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] waddr_a,
  input  logic [LANE_W-1:0]     wdata_a,
  output logic [LANE_W-1:0]     rdata_a,
  input  logic                  re_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  input  logic [ADDR_WIDTH-1:0] waddr_b,
  input  logic [LANE_W-1:0]     wdata_b,
  output logic [LANE_W-1:0]     rdata_b
);

  logic [LANE_W-1:0] mem [2**ADDR_WIDTH];

  // Collisions are resolved upstream, so the two writes never share an address.
  always_ff @(posedge clk) begin
    if (we_b) mem[waddr_b] <= wdata_b;
    if (we_a) mem[waddr_a] <= wdata_a;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= mem[raddr_a];
      if (re_b) rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/bram_lane_clr.sv
// Byte-addressable dual-port RAM with per-lane collision arbitration, optional
// output register and a clear engine that sweeps every word to CLEAR_VALUE.
module bram_lane_clr
  import bram_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 12,
  parameter int         LANES          = 4,
  parameter bit         OUT_REG        = 1'b0,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] CLEAR_VALUE    = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic                    clear_state,
  input  logic                    clken_a,
  input  logic                    clken_b,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [LANES-1:0]        we_a,
  input  logic [LANES-1:0]        we_b,
  input  logic [LANE_W*LANES-1:0] data_in_a,
  input  logic [LANE_W*LANES-1:0] data_in_b,
  output logic [LANE_W*LANES-1:0] data_out_a,
  output logic [LANE_W*LANES-1:0] data_out_b
);

  localparam int                    DW   = LANE_W * LANES;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  clr_state_t            state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  boot_pend;
  logic                  sweep;
  logic                  same_addr;
  logic [DW-1:0]         q_a;
  logic [DW-1:0]         q_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clr_addr  <= '0;
      boot_pend <= CLEAR_ON_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (boot_pend || clear_req) begin
            state     <= SWEEP;
            clr_addr  <= '0;
            boot_pend <= 1'b0;
          end
        end
        SWEEP: begin
          if (clr_addr == LAST) state <= IDLE;
          else                  clr_addr <= clr_addr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sweep       = (state == SWEEP);
  assign clear_busy  = sweep;
  assign clear_state = state;
  assign same_addr   = (addr_a == addr_b);

  // Port contract: clken_x qualifies the whole access; with clken_x low the port
  // neither reads nor writes and its output holds. The sweep borrows the write
  // half of port A, so external reads keep flowing while the array is cleared.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic wr_a;
    logic wr_b;
    assign wr_a = !reset && (sweep || (clken_a && we_a[i]));
    assign wr_b = !reset && !sweep && clken_b && we_b[i] &&
                  !(clken_a && we_a[i] && same_addr);

    bram_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .re_a    (clken_a),
      .we_a    (wr_a),
      .raddr_a (addr_a),
      .waddr_a (sweep ? clr_addr : addr_a),
      .wdata_a (sweep ? CLEAR_VALUE : lane_slice(MAX_W'(data_in_a), i)),
      .rdata_a (q_a[i*LANE_W +: LANE_W]),
      .re_b    (clken_b),
      .we_b    (wr_b),
      .raddr_b (addr_b),
      .waddr_b (addr_b),
      .wdata_b (lane_slice(MAX_W'(data_in_b), i)),
      .rdata_b (q_b[i*LANE_W +: LANE_W])
    );
  end

  if (OUT_REG) begin : g_oreg
    logic          en_a_q;
    logic          en_b_q;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;

    // Advance only when a read actually completed, so outputs hold otherwise.
    always_ff @(posedge clk) begin
      if (reset) begin
        en_a_q <= 1'b0;
        en_b_q <= 1'b0;
        r_a    <= '0;
        r_b    <= '0;
      end else begin
        en_a_q <= clken_a;
        en_b_q <= clken_b;
        if (en_a_q) r_a <= q_a;
        if (en_b_q) r_b <= q_b;
      end
    end

    assign data_out_a = r_a;
    assign data_out_b = r_b;
  end else begin : g_direct
    assign data_out_a = q_a;
    assign data_out_b = q_b;
  end

endmodule

// File: tb/tb_bram_lane_clr.sv
// Bench for bram_lane_clr: two instances (direct / registered output, clear
// values 00 / FF) share stimulus and are checked against an array model.
module tb_bram_lane_clr;

  localparam int AW    = 4;
  localparam int LN    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, clear_req, clken_a, clken_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [LN-1:0] we_a, we_b;
  logic [DW-1:0] data_in_a, data_in_b;
  logic [DW-1:0] out_a0, out_b0, out_a1, out_b1;
  logic          busy0, busy1, st0, st1;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [DW-1:0] mem [2][DEPTH];
  logic [7:0]    cv [2];
  int            sweep_left;
  bit            pend;
  logic [DW-1:0] ea [2], eb [2], pa [2], pb [2];
  bit            va [2], vb [2], pva [2], pvb [2], pen_a [2], pen_b [2];
  int            busy_cycles;

  always #5 clk = ~clk;

  bram_lane_clr #(.ADDR_WIDTH(AW), .LANES(LN), .OUT_REG(1'b0),
                  .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00)) dut0 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(busy0),
    .clear_state(st0), .clken_a(clken_a), .clken_b(clken_b),
    .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a), .we_b(we_b),
    .data_in_a(data_in_a), .data_in_b(data_in_b),
    .data_out_a(out_a0), .data_out_b(out_b0)
  );

  bram_lane_clr #(.ADDR_WIDTH(AW), .LANES(LN), .OUT_REG(1'b1),
                  .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hFF)) dut1 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(busy1),
    .clear_state(st1), .clken_a(clken_a), .clken_b(clken_b),
    .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a), .we_b(we_b),
    .data_in_a(data_in_a), .data_in_b(data_in_b),
    .data_out_a(out_a1), .data_out_b(out_b1)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the behavioural memory: reads see pre-edge contents,
  // a sweep writes one whole word per edge, port A beats port B per lane.
  task automatic model_edge();
    logic [DW-1:0] rda, rdb;
    bit busy_now;
    busy_now = (sweep_left > 0);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        ea[k] = '0; eb[k] = '0; va[k] = 1; vb[k] = 1;
        pa[k] = '0; pb[k] = '0; pva[k] = 1; pvb[k] = 1;
        pen_a[k] = 0; pen_b[k] = 0;
      end else begin
        rda = mem[k][addr_a];
        rdb = mem[k][addr_b];
        if (k == 0) begin
          if (clken_a) begin ea[0] = rda; va[0] = !busy_now; end
          if (clken_b) begin eb[0] = rdb; vb[0] = !busy_now; end
        end else begin
          if (pen_a[1]) begin ea[1] = pa[1]; va[1] = pva[1]; end
          if (pen_b[1]) begin eb[1] = pb[1]; vb[1] = pvb[1]; end
          if (clken_a) begin pa[1] = rda; pva[1] = !busy_now; end
          if (clken_b) begin pb[1] = rdb; pvb[1] = !busy_now; end
          pen_a[1] = clken_a;
          pen_b[1] = clken_b;
        end
        if (busy_now) begin
          mem[k][DEPTH - sweep_left] = {4{cv[k]}};
        end else begin
          for (int l = 0; l < LN; l++) begin
            if (clken_b && we_b[l]) mem[k][addr_b][8*l +: 8] = data_in_b[8*l +: 8];
            if (clken_a && we_a[l]) mem[k][addr_a][8*l +: 8] = data_in_a[8*l +: 8];
          end
        end
      end
    end
    if (reset) begin
      sweep_left = 0;
      pend       = 1;
    end else if (busy_now) begin
      sweep_left--;
    end else if (pend || clear_req) begin
      sweep_left = DEPTH;
      pend       = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy0", {31'b0, busy0}, {31'b0, sweep_left > 0});
    chk("busy1", {31'b0, busy1}, {31'b0, sweep_left > 0});
    if (va[0]) chk("d0_out_a", out_a0, ea[0]);
    if (vb[0]) chk("d0_out_b", out_b0, eb[0]);
    if (va[1]) chk("d1_out_a", out_a1, ea[1]);
    if (vb[1]) chk("d1_out_b", out_b1, eb[1]);
    if (busy0) busy_cycles++;
  endtask

  task automatic idle();
    clken_a = 0; clken_b = 0; we_a = '0; we_b = '0; clear_req = 0;
  endtask

  task automatic wait_sweep_done();
    for (int n = 0; n < 60; n++) begin
      step();
      if (!busy0 && sweep_left == 0) break;
    end
  endtask

  initial begin
    cv[0] = 8'h00; cv[1] = 8'hFF;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < DEPTH; a++) mem[k][a] = 'x;
    sweep_left = 0; pend = 1;
    reset = 1; addr_a = '0; addr_b = '0; data_in_a = '0; data_in_b = '0;
    idle();

    // reset values, then the boot sweep
    for (int n = 0; n < 3; n++) step();
    chk("rst_out_a0", out_a0, 32'h0);
    chk("rst_out_b1", out_b1, 32'h0);
    reset = 0;
    busy_cycles = 0;
    wait_sweep_done();
    chk("boot_sweep_len", busy_cycles, 32'd16);

    for (int i = 0; i < DEPTH; i++) begin
      clken_a = 1; addr_a = AW'(i);
      clken_b = 1; addr_b = AW'(DEPTH - 1 - i);
      step();
      chk("boot_clr_a0", out_a0, 32'h0);
      chk("boot_clr_b0", out_b0, 32'h0);
    end
    idle(); step();

    // partial lane write
    clken_a = 1; addr_a = 4'd5; we_a = 4'b0101; data_in_a = 32'hDEADBEEF;
    step();
    we_a = '0;
    step();
    chk("lane_wr_d0", out_a0, 32'h00AD00EF);
    idle(); step();
    chk("lane_wr_d1", out_a1, 32'hFFADFFEF);

    // same-cycle collision on addr 7
    clken_a = 1; addr_a = 4'd7; we_a = 4'b0011; data_in_a = 32'h11111111;
    clken_b = 1; addr_b = 4'd7; we_b = 4'b0110; data_in_b = 32'h22222222;
    step();
    we_a = '0; we_b = '0; clken_b = 0;
    step();
    chk("collide_d0", out_a0, 32'h00221111);
    idle(); step();
    chk("collide_d1", out_a1, 32'hFF221111);

    // read-during-write on port A
    clken_a = 1; addr_a = 4'd3; we_a = 4'hF; data_in_a = 32'hAAAAAAAA;
    step();
    data_in_a = 32'h55555555;
    step();
    chk("rdw_old", out_a0, 32'hAAAAAAAA);
    we_a = '0;
    step();
    chk("rdw_new", out_a0, 32'h55555555);
    idle(); step();

    // requested clear with a dropped write and an ignored second request
    busy_cycles = 0;
    clear_req = 1; step(); clear_req = 0;
    step(); step();
    clken_a = 1; addr_a = 4'd2; we_a = 4'hF; data_in_a = 32'h12345678;
    step();
    idle(); clear_req = 1; step(); clear_req = 0;
    wait_sweep_done();
    chk("req_sweep_len", busy_cycles, 32'd16);
    clken_b = 1; addr_b = 4'd2;
    step(); idle(); step();
    chk("drop_wr_d0", out_b0, 32'h00000000);
    chk("drop_wr_d1", out_b1, 32'hFFFFFFFF);

    // reset in the middle of a sweep
    clear_req = 1; step(); clear_req = 0;
    for (int n = 0; n < 9; n++) step();
    reset = 1; step();
    chk("mid_rst_busy", {31'b0, busy0}, 32'd0);
    step();
    reset = 0;
    busy_cycles = 0;
    wait_sweep_done();
    chk("restart_sweep_len", busy_cycles, 32'd16);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      clken_a   = 1'($urandom_range(0, 3) != 0);
      clken_b   = 1'($urandom_range(0, 3) != 0);
      addr_a    = AW'($urandom_range(0, DEPTH - 1));
      addr_b    = ($urandom_range(0, 3) == 0) ? addr_a : AW'($urandom_range(0, DEPTH - 1));
      we_a      = LN'($urandom_range(0, 15));
      we_b      = LN'($urandom_range(0, 15));
      data_in_a = $urandom;
      data_in_b = $urandom;
      clear_req = 1'($urandom_range(0, 99) == 0);
      step();
    end
    idle();
    wait_sweep_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
